// File: rtl/jk_counter_pkg.sv
// Shared constants and parameter checks for the JK-cell up/down counter.
package jk_counter_pkg;

    localparam int DEFAULT_WIDTH   = 4;
    localparam int DEFAULT_MODULUS = 10;

    // MODULUS must give at least two states and fit in WIDTH bits.
    function automatic bit modulus_ok(input int width, input int modulus);
        longint unsigned span;
        if (width < 1 || width > 31) return 1'b0;
        span = longint'(1) << width;
        return (modulus >= 2) && (longint'(modulus) <= span);
    endfunction

endpackage

// File: rtl/jk_ff_r.sv
// Single JK flip-flop with synchronous active-high clear.
module jk_ff_r (
    input  logic clk,
    input  logic rst,
    input  logic J,
    input  logic K,
    output logic Q,
    output logic Qbar
);

    // NOTE: sequential state is written with <= so every cell samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q <= 1'b0;
        end else begin
            case ({J, K})
                2'b01:   Q <= 1'b0;
                2'b10:   Q <= 1'b1;
                2'b11:   Q <= ~Q;
                default: Q <= Q;
            endcase
        end
    end

    assign Qbar = ~Q;

endmodule

// File: rtl/jk_updown_counter.sv
// Modulo-N up/down counter with saturating parallel load, stored in JK cells
// whose excitation is derived from the desired next value.
module jk_updown_counter
    import jk_counter_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = DEFAULT_MODULUS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec
);

    if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
        $error("jk_updown_counter: MODULUS %0d out of range for WIDTH %0d", MODULUS, WIDTH);
    end

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] next_val;
    logic [WIDTH-1:0] count_n;

    // NOTE: next_val gets a default first so no path through the block infers a latch.
    always_comb begin
        next_val = count;
        if (load) begin
            next_val = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;
        end else if (en) begin
            if (up) next_val = (count == MAX_VAL) ? '0 : count + 1'b1;
            else    next_val = (count == '0) ? MAX_VAL : count - 1'b1;
        end
    end

    // Only changing bits are excited, so J=K=1 can never be presented.
    assign j_vec = rst ? '0 : (next_val & count_n);
    assign k_vec = rst ? '0 : (~next_val & count);

    assign tc = ~rst & en & ~load & (up ? (count == MAX_VAL) : (count == '0));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_ff_r u_cell (
            .clk  (clk),
            .rst  (rst),
            .J    (j_vec[i]),
            .K    (k_vec[i]),
            .Q    (count[i]),
            .Qbar (count_n[i])
        );
    end

endmodule

// File: tb/tb_jk_updown_counter.sv
// Randomized and directed bench for jk_updown_counter (MODULUS 10 and 16 instances).
module tb_jk_updown_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] load_val;
    logic [3:0] count10, j10, k10, count16, j16, k16;
    logic       tc10, tc16;

    int tests = 0;
    int fails = 0;
    int exp10, exp16;
    bit valid = 1'b0;

    always #5 clk = ~clk;

    jk_updown_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count10), .tc(tc10), .j_vec(j10), .k_vec(k10)
    );

    jk_updown_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .count(count16), .tc(tc16), .j_vec(j16), .k_vec(k16)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: next count from the priority rules using modular arithmetic.
    function automatic int model_next(input int cur, input int m);
        if (rst)  return 0;
        if (load) return (int'(load_val) < m) ? int'(load_val) : m - 1;
        if (en)   return up ? (cur + 1) % m : (cur + m - 1) % m;
        return cur;
    endfunction

    function automatic bit model_tc(input int cur, input int m);
        return !rst && en && !load && (up ? (cur == m - 1) : (cur == 0));
    endfunction

    task automatic check_model(input string name, input int cur, input int m,
                               input logic [3:0] cnt, input logic t,
                               input logic [3:0] j, input logic [3:0] k);
        logic [3:0] q, n, ej, ek;
        q  = 4'(cur);
        n  = 4'(model_next(cur, m));
        ej = rst ? 4'h0 : (n & ~q);
        ek = rst ? 4'h0 : (~n & q);
        check({name, "_count"}, 32'(cnt), 32'(cur));
        check({name, "_tc"}, 32'(t), 32'(model_tc(cur, m)));
        check({name, "_j"}, 32'(j), 32'(ej));
        check({name, "_k"}, 32'(k), 32'(ek));
        check({name, "_j_and_k"}, 32'(j & k), 32'd0);
    endtask

    task automatic drive(input logic r, input logic e, input logic u,
                         input logic l, input logic [3:0] lv);
        rst = r; en = e; up = u; load = l; load_val = lv;
    endtask

    task automatic half();
        @(negedge clk);
    endtask

    // Compare against the model, take the edge, then advance the model.
    task automatic finish();
        int n10, n16;
        if (valid) begin
            check_model("m10", exp10, 10, count10, tc10, j10, k10);
            check_model("m16", exp16, 16, count16, tc16, j16, k16);
        end
        n10 = model_next(exp10, 10);
        n16 = model_next(exp16, 16);
        @(posedge clk);
        exp10 = n10;
        exp16 = n16;
        if (rst) valid = 1'b1;
        #1;
    endtask

    task automatic tick(input logic r, input logic e, input logic u,
                        input logic l, input logic [3:0] lv);
        drive(r, e, u, l, lv);
        half();
        finish();
    endtask

    initial begin
        exp10 = 0;
        exp16 = 0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        #1;

        // Reset, then count up 12 times through the wrap.
        tick(1'b1, 1'b1, 1'b1, 1'b1, 4'd6);
        check("reset_count", 32'(count10), 32'd0);
        for (int i = 0; i < 12; i++) tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("up12_count", 32'(count10), 32'd2);

        // Down from 0 wraps to MODULUS-1.
        tick(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        half();
        check("down_tc", 32'(tc10), 32'd1);
        check("down_j", 32'(j10), 32'b1001);
        check("down_k", 32'(k10), 32'b0000);
        finish();
        check("down_wrap", 32'(count10), 32'd9);

        // Out-of-range load saturates and suppresses tc.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd13);
        half();
        check("load_tc", 32'(tc10), 32'd0);
        finish();
        check("load_sat", 32'(count10), 32'd9);
        check("load16", 32'(count16), 32'd13);

        // 7 -> 8 excitation, then hold.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'd7);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        half();
        check("step7_j", 32'(j10), 32'b1000);
        check("step7_k", 32'(k10), 32'b0111);
        finish();
        check("step7_count", 32'(count10), 32'd8);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        half();
        check("hold_j", 32'(j10), 32'd0);
        check("hold_k", 32'(k10), 32'd0);
        finish();
        check("hold_count", 32'(count10), 32'd8);

        // Reset beats load; first edge after reset counts from 0.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3);
        half();
        check("rst_tc", 32'(tc10), 32'd0);
        check("rst_jk", 32'({j10, k10}), 32'd0);
        finish();
        check("rst_count", 32'(count10), 32'd0);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("post_rst", 32'(count10), 32'd1);

        // Full-range instance wraps at 15 and 0.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        tick(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        check("m16_up_wrap", 32'(count16), 32'd0);
        tick(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        check("m16_down_wrap", 32'(count16), 32'd15);

        // Random run.
        for (int i = 0; i < 80; i++) begin
            tick(($urandom_range(15) == 0), ($urandom_range(3) != 0), 1'($urandom),
                 ($urandom_range(5) == 0), 4'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
